// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data cache sequencing controller
package dcache_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_VICTIM,
        ST_WRITEBACK,
        ST_REFILL,
        ST_ALLOCATE
    } state_e;

    // Cache group command, packed as {enable, compare, read}
    localparam logic [2:0] CMD_NONE      = 3'b000;
    localparam logic [2:0] CMD_LOOKUP_LD = 3'b111;
    localparam logic [2:0] CMD_LOOKUP_ST = 3'b110;
    localparam logic [2:0] CMD_VICTIM    = 3'b101;
    localparam logic [2:0] CMD_ALLOCATE  = 3'b100;

endpackage

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - lookup / victim / writeback / refill / allocate sequencer for a 2-way data cache group
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = dcache_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              stall,
    output logic              c_enable,
    output logic              c_compare,
    output logic              c_read,
    output logic [ADDR_W-1:0] c_address,
    output logic [31:0]       c_data,
    output logic [3:0]        c_byte_w_en,
    output logic [LINE_W-1:0] c_line_in,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic [31:0]       c_data_out,
    input  logic [ADDR_W-1:0] c_address_out,
    input  logic [LINE_W-1:0] c_line_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                retry_q, retry_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0]   refill_q, refill_d;
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;
    logic [2:0]          cmd;
    logic                mem_fire;
    logic [ADDR_W-1:0]   refill_addr;
    logic [ADDR_W-1:0]   victim_addr;
    logic                unused_offset;

    assign refill_addr   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign victim_addr   = {c_address_out[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign unused_offset = ^c_address_out[OFFSET_W-1:0];
    assign mem_fire      = mem_req_q & mem_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        retry_d      = retry_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        refill_d     = refill_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        cmd          = CMD_NONE;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    retry_d = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                cmd = we_q ? CMD_LOOKUP_ST : CMD_LOOKUP_LD;
                // Only the first attempt of a request counts toward the statistics
                if (c_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0 : c_data_out;
                    if (!retry_q) hit_count_d = hit_count_q + 32'd1;
                    state_d = ST_IDLE;
                end else begin
                    if (!retry_q) miss_count_d = miss_count_q + 32'd1;
                    state_d = ST_VICTIM;
                end
            end
            ST_VICTIM: begin
                cmd       = CMD_VICTIM;
                mem_req_d = 1'b1;
                if (c_dirty && c_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = victim_addr;
                    mem_wdata_d = c_line_out;
                    state_d     = ST_WRITEBACK;
                end else begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = refill_addr;
                    mem_wdata_d = '0;
                    state_d     = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                // mem_req drops for one cycle before the refill read is raised
                if (mem_fire) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = refill_addr;
                    mem_wdata_d = '0;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_fire) begin
                    refill_d   = mem_rdata;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                    state_d    = ST_ALLOCATE;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            ST_ALLOCATE: begin
                cmd     = CMD_ALLOCATE;
                retry_d = 1'b1;
                state_d = ST_LOOKUP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            retry_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            refill_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            retry_q      <= retry_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign {c_enable, c_compare, c_read} = cmd;
    assign c_address   = c_enable ? addr_q : '0;
    assign c_data      = (state_q == ST_LOOKUP && we_q) ? wdata_q : 32'h0;
    assign c_byte_w_en = (state_q == ST_LOOKUP && we_q) ? be_q : 4'h0;
    assign c_line_in   = (state_q == ST_ALLOCATE) ? refill_q : '0;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign stall      = req_valid & ~resp_valid_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - bench for dcache_ctrl with a 2-way cache group model, memory model and flat reference memory
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_be;
    logic         req_ready, resp_valid, stall;
    logic [31:0]  resp_rdata;
    logic         c_enable, c_compare, c_read;
    logic [31:0]  c_address, c_data;
    logic [3:0]   c_byte_w_en;
    logic [255:0] c_line_in;
    logic         c_hit, c_dirty, c_valid;
    logic [31:0]  c_data_out, c_address_out;
    logic [255:0] c_line_out;
    logic         mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
        .c_enable(c_enable), .c_compare(c_compare), .c_read(c_read),
        .c_address(c_address), .c_data(c_data), .c_byte_w_en(c_byte_w_en),
        .c_line_in(c_line_in), .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_data_out(c_data_out), .c_address_out(c_address_out), .c_line_out(c_line_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] init_word(input int w);
        return {8'hC0, 8'(w), 8'(w * 7 + 3), 8'h5A};
    endfunction

    function automatic logic [255:0] init_line(input int l);
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = init_word(l * 8 + j);
        return v;
    endfunction

    // Cache group model: 4 sets x 2 ways, round-robin victim pointer
    logic [255:0] cl_data  [4][2];
    logic [26:0]  cl_line  [4][2];
    logic         cl_valid [4][2] = '{default: 1'b0};
    logic         cl_dirty [4][2] = '{default: 1'b0};
    logic         cl_ptr   [4]    = '{default: 1'b0};
    logic         cl_way   [4]    = '{default: 1'b0};
    logic [1:0]   g_set;
    logic         g_way;
    logic [255:0] g_new_line;

    always_comb begin
        c_hit = 1'b0; c_dirty = 1'b0; c_valid = 1'b0; c_data_out = '0;
        c_address_out = '0; c_line_out = '0; g_way = 1'b0; g_new_line = '0;
        g_set = c_address[6:5];
        if (c_enable && c_compare) begin
            for (int w = 0; w < 2; w++) begin
                if (cl_valid[g_set][w] && cl_line[g_set][w] == c_address[31:5]) begin
                    c_hit = 1'b1;
                    g_way = w[0];
                end
            end
            if (c_hit) begin
                g_new_line = cl_data[g_set][g_way];
                c_data_out = g_new_line[{c_address[4:2], 5'b0} +: 32];
                for (int b = 0; b < 4; b++)
                    if (c_byte_w_en[b]) g_new_line[{c_address[4:2], 5'b0} + b * 8 +: 8] = c_data[b*8 +: 8];
            end
        end else if (c_enable && c_read) begin
            c_valid       = cl_valid[g_set][cl_ptr[g_set]];
            c_dirty       = cl_dirty[g_set][cl_ptr[g_set]];
            c_address_out = {cl_line[g_set][cl_ptr[g_set]], 5'b0};
            c_line_out    = cl_data[g_set][cl_ptr[g_set]];
        end
    end

    always @(posedge clk) begin
        if (c_enable && c_compare && !c_read && c_hit) begin
            cl_data[g_set][g_way]  <= g_new_line;
            cl_dirty[g_set][g_way] <= 1'b1;
        end
        if (c_enable && !c_compare && c_read) begin
            cl_way[g_set] <= cl_ptr[g_set];
            cl_ptr[g_set] <= ~cl_ptr[g_set];
        end
        if (c_enable && !c_compare && !c_read) begin
            cl_data[g_set][cl_way[g_set]]  <= c_line_in;
            cl_line[g_set][cl_way[g_set]]  <= c_address[31:5];
            cl_valid[g_set][cl_way[g_set]] <= 1'b1;
            cl_dirty[g_set][cl_way[g_set]] <= 1'b0;
        end
    end

    // Main memory model: 32 lines, random 1..4 cycle latency
    logic [255:0] mem_arr [32];
    logic         mem_wr  [32] = '{default: 1'b0};
    int           lat;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ready <= 1'b0;
            lat       <= 0;
        end else begin
            mem_ready <= 1'b0;
            if (mem_req && !mem_ready) begin
                if (lat == 0) begin
                    mem_ready <= 1'b1;
                    lat       <= int'($urandom_range(3, 0));
                    if (mem_we) begin
                        mem_arr[mem_addr[9:5]] <= mem_wdata;
                        mem_wr[mem_addr[9:5]]  <= 1'b1;
                    end else begin
                        mem_rdata <= mem_wr[mem_addr[9:5]] ? mem_arr[mem_addr[9:5]] : init_line(int'(mem_addr[9:5]));
                    end
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    // Reference: flat word memory plus FIFO residency per set
    logic [31:0]  ref_mem [256];
    int           resident [4][$];
    bit           line_dirty [32];
    logic [31:0]  hit_exp, miss_exp;
    int           n_cmp, n_fail;
    int           last_cycles;
    logic [31:0]  last_rdata, last_wb_addr, last_rf_addr, last_addr;
    logic [255:0] last_wb_line;
    bit           last_wb_seen;

    task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        int line, set, victim, miss_lookups;
        bit exp_hit, exp_wb, rf_seen;
        logic [31:0] exp_rd, m;
        logic [255:0] exp_wb_line;
        line = int'(a[9:5]); set = line % 4;
        exp_hit = 0; exp_wb = 0; victim = 0; exp_wb_line = '0;
        foreach (resident[set][i]) if (resident[set][i] == line) exp_hit = 1;
        if (!exp_hit) begin
            miss_exp = miss_exp + 32'd1;
            if (resident[set].size() == 2) begin
                victim = resident[set].pop_front();
                exp_wb = line_dirty[victim];
                for (int j = 0; j < 8; j++) exp_wb_line[j*32 +: 32] = ref_mem[victim*8 + j];
            end
            resident[set].push_back(line);
            line_dirty[line] = 0;
        end else begin
            hit_exp = hit_exp + 32'd1;
        end
        exp_rd = ref_mem[a[9:2]];
        if (we) begin
            m = ref_mem[a[9:2]];
            for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[a[9:2]] = m;
            line_dirty[line] = 1;
        end

        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL req_ready_idle: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        last_cycles = 0; last_wb_seen = 0; rf_seen = 0; miss_lookups = 0;
        last_wb_addr = '0; last_wb_line = '0; last_rf_addr = '0;
        while (1) begin
            @(negedge clk);
            last_cycles++;
            if (last_cycles == 1) begin
                n_cmp++;
                if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", stall); end
            end
            if (c_enable && c_compare && !c_hit) miss_lookups++;
            if (mem_req && mem_we && !last_wb_seen) begin
                last_wb_seen = 1; last_wb_addr = mem_addr; last_wb_line = mem_wdata;
            end
            if (mem_req && !mem_we && !rf_seen) begin rf_seen = 1; last_rf_addr = mem_addr; end
            if (resp_valid || last_cycles >= 300) break;
        end
        req_valid = 1'b0;
        last_rdata = resp_rdata;
        last_addr  = a;

        n_cmp++;
        if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL resp_timeout addr=%h: no resp_valid in %0d cycles", a, last_cycles); end
        n_cmp++;
        if (exp_hit && last_cycles != 2) begin n_fail++; $display("FAIL hit_latency addr=%h: got %0d expected 2", a, last_cycles); end
        else if (!exp_hit && last_cycles < 6) begin n_fail++; $display("FAIL miss_latency addr=%h: got %0d expected >=6", a, last_cycles); end
        n_cmp++;
        if (miss_lookups != (exp_hit ? 0 : 1)) begin
            n_fail++; $display("FAIL missed_lookups addr=%h: got %0d expected %0d", a, miss_lookups, exp_hit ? 0 : 1);
        end
        if (!we) begin
            n_cmp++;
            if (resp_rdata !== exp_rd) begin n_fail++; $display("FAIL load_data addr=%h: got %h expected %h", a, resp_rdata, exp_rd); end
        end
        n_cmp++;
        if (last_wb_seen != exp_wb) begin n_fail++; $display("FAIL writeback_seen addr=%h: got %b expected %b", a, last_wb_seen, exp_wb); end
        if (exp_wb && last_wb_seen) begin
            n_cmp++;
            if (last_wb_addr !== 32'(victim * 32) || last_wb_line !== exp_wb_line) begin
                n_fail++; $display("FAIL writeback_line: got addr %h expected %h (data %0s)", last_wb_addr, victim * 32,
                                   last_wb_line === exp_wb_line ? "ok" : "differs");
            end
        end
        if (!exp_hit) begin
            n_cmp++;
            if (last_rf_addr !== 32'(line * 32)) begin n_fail++; $display("FAIL refill_addr: got %h expected %h", last_rf_addr, line * 32); end
        end
        n_cmp++;
        if (hit_count !== hit_exp || miss_count !== miss_exp) begin
            n_fail++; $display("FAIL counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d", hit_count, miss_count, hit_exp, miss_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_req, resp_valid, c_enable, stall} !== 4'b0 || hit_count !== 0 || miss_count !== 0) begin
            n_fail++; $display("FAIL reset_outputs: got mem_req=%b resp=%b en=%b hit=%0d miss=%0d expected all 0",
                               mem_req, resp_valid, c_enable, hit_count, miss_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_cold_load();
        do_req(32'h100, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (last_rf_addr !== 32'h100 || last_rdata !== init_word(64) || miss_count !== 1 || hit_count !== 0) begin
            n_fail++; $display("FAIL cold_load: got rf=%h data=%h miss=%0d hit=%0d expected 100 %h 1 0",
                               last_rf_addr, last_rdata, miss_count, hit_count, init_word(64));
        end
    endtask

    task automatic test_hit();
        do_req(32'h104, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (last_cycles != 2 || hit_count !== 1) begin
            n_fail++; $display("FAIL load_hit: got latency=%0d hit=%0d expected 2 1", last_cycles, hit_count);
        end
    endtask

    task automatic test_store_merge();
        logic [31:0] iw;
        iw = init_word(65);
        do_req(32'h104, 1'b1, 32'hDEADBEEF, 4'b0011);
        do_req(32'h104, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (last_rdata !== {iw[31:16], 16'hBEEF}) begin
            n_fail++; $display("FAIL store_merge: got %h expected %h", last_rdata, {iw[31:16], 16'hBEEF});
        end
    endtask

    task automatic test_writeback();
        do_req(32'h200, 1'b1, 32'h12345678, 4'hF);
        do_req(32'h300, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (!last_wb_seen || last_wb_addr !== 32'h100 || last_wb_line[32 +: 16] !== 16'hBEEF) begin
            n_fail++; $display("FAIL writeback_victim: got seen=%b addr=%h word1=%h expected 1 100 xxxxBEEF",
                               last_wb_seen, last_wb_addr, last_wb_line[32 +: 32]);
        end
        do_req(32'h000, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (!last_wb_seen || last_wb_addr !== 32'h200 || last_wb_line[0 +: 32] !== 32'h12345678) begin
            n_fail++; $display("FAIL writeback_second: got seen=%b addr=%h word0=%h expected 1 200 12345678",
                               last_wb_seen, last_wb_addr, last_wb_line[0 +: 32]);
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(255, 0)) << 2;
            do_req(a, 1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 1)));
        end
    endtask

    task automatic test_counter_wrap();
        force dut.hit_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count_q;
        hit_exp = 32'hFFFF_FFFF;
        do_req(last_addr, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (hit_count !== 32'h0) begin n_fail++; $display("FAIL hit_wrap: got %h expected 0", hit_count); end
    endtask

    task automatic test_reset_mid_refill();
        int l, waited;
        bit found;
        l = 0; found = 0;
        for (int k = 0; k < 32 && !found; k++) begin
            bit res;
            res = 0;
            foreach (resident[k % 4][i]) if (resident[k % 4][i] == k) res = 1;
            if (!res) begin l = k; found = 1; end
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(l * 32); req_wdata = '0; req_be = '0;
        waited = 0;
        while (!(mem_req && !mem_we) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (!(mem_req && !mem_we)) begin n_fail++; $display("FAIL reach_refill: got mem_req=%b mem_we=%b expected 1 0", mem_req, mem_we); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || c_enable !== 1'b0 || hit_count !== 0 || miss_count !== 0) begin
            n_fail++; $display("FAIL async_reset: got mem_req=%b en=%b hit=%0d miss=%0d expected 0 0 0 0",
                               mem_req, c_enable, hit_count, miss_count);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || hit_count !== 0 || miss_count !== 0) begin
            n_fail++; $display("FAIL post_reset_idle: got ready=%b mem_req=%b resp=%b hit=%0d miss=%0d expected 1 0 0 0 0",
                               req_ready, mem_req, resp_valid, hit_count, miss_count);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; hit_exp = '0; miss_exp = '0;
        for (int w = 0; w < 256; w++) ref_mem[w] = init_word(w);
        for (int l = 0; l < 32; l++) line_dirty[l] = 0;
        test_reset();
        test_cold_load();
        test_hit();
        test_store_merge();
        test_writeback();
        test_random_traffic();
        test_counter_wrap();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
